// File: rtl/dmem_pkg.sv
// Shared definitions for the MIPS data memory: access-size encodings, FSM
// state type, default data-segment base and the byte-lane enable helper.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Little-endian lane mask for a store of the given size at byte lane 'lane'.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] en;
    en = 4'b0000;
    case (size)
      SIZE_BYTE: en = 4'b0001 << lane;
      SIZE_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: en = 4'b1111;
      default:   en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// MEMORY_DEPTH x 32 data array split into four byte lanes, each with its own
// write enable; the read is synchronous and holds its value until the next read.
module dmem_byte_ram #(
  parameter int MEMORY_DEPTH = 64,
  parameter int IDX_W        = $clog2(MEMORY_DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [3:0]       byte_en,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [MEMORY_DEPTH];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk) begin
      if (wr_en && byte_en[gi]) begin
        lane_mem[index] <= wr_data[8*gi +: 8];
      end
      if (rd_en) begin
        rd_byte_reg <= lane_mem[index];
      end
    end

    assign rd_data[8*gi +: 8] = rd_byte_reg;
  end

endmodule

// File: rtl/data_memory_unit.sv
// MIPS data memory with valid/ready requests, programmable read latency,
// byte/half/word access, sign/zero-extended loads and address-fault reporting.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 64,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  write_enable,
  input  logic [1:0]            size,
  input  logic                  unsigned_load,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  error
);

  localparam int         IDX_W       = $clog2(MEMORY_DEPTH);
  localparam logic [3:0] WAIT_CYCLES = 4'(READ_LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        store_reg;
  logic        fault_reg;
  logic [1:0]  lane_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic        resp_valid_reg, resp_valid_next;
  logic [31:0] read_data_reg, read_data_next;
  logic        error_reg, error_next;

  logic             accept;
  logic             fault;
  logic [31:0]      word_offset;
  logic [IDX_W-1:0] index;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;
  logic [31:0]      load_value;

  assign accept      = req_valid && (state_reg == IDLE);
  assign word_offset = (address - BASE_ADDRESS) >> 2;
  assign index       = word_offset[IDX_W-1:0];

  always_comb begin
    fault = 1'b0;
    if (address < BASE_ADDRESS) fault = 1'b1;
    if (word_offset >= 32'(MEMORY_DEPTH)) fault = 1'b1;
    case (size)
      SIZE_BYTE: ;
      SIZE_HALF: if (address[0]) fault = 1'b1;
      SIZE_WORD: if (address[1:0] != 2'b00) fault = 1'b1;
      default:   fault = 1'b1;
    endcase
  end

  // Replicate right-justified store data across lanes; the byte enables pick the target lanes.
  always_comb begin
    case (size)
      SIZE_BYTE: wr_data = {4{WriteData[7:0]}};
      SIZE_HALF: wr_data = {2{WriteData[15:0]}};
      default:   wr_data = WriteData;
    endcase
  end

  dmem_byte_ram #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .IDX_W        (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept && write_enable && !fault),
    .rd_en   (accept && !write_enable && !fault),
    .byte_en (lane_enable(size, address[1:0])),
    .index   (index),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always_comb begin
    case (size_reg)
      SIZE_BYTE: load_value = unsigned_reg
                   ? {24'h0, rd_data[{lane_reg, 3'b000} +: 8]}
                   : {{24{rd_data[{lane_reg, 3'b111}]}}, rd_data[{lane_reg, 3'b000} +: 8]};
      SIZE_HALF: begin
        if (lane_reg[1]) begin
          load_value = unsigned_reg ? {16'h0, rd_data[31:16]} : {{16{rd_data[31]}}, rd_data[31:16]};
        end else begin
          load_value = unsigned_reg ? {16'h0, rd_data[15:0]} : {{16{rd_data[15]}}, rd_data[15:0]};
        end
      end
      default:   load_value = rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      store_reg      <= 1'b0;
      fault_reg      <= 1'b0;
      lane_reg       <= 2'b00;
      size_reg       <= SIZE_WORD;
      unsigned_reg   <= 1'b0;
      resp_valid_reg <= 1'b0;
      read_data_reg  <= 32'h0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= resp_valid_next;
      read_data_reg  <= read_data_next;
      error_reg      <= error_next;
      if (accept) begin
        store_reg    <= write_enable;
        fault_reg    <= fault;
        lane_reg     <= address[1:0];
        size_reg     <= size;
        unsigned_reg <= unsigned_load;
        cnt_reg      <= write_enable ? 4'd0 : WAIT_CYCLES;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (write_enable || READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT:    if (cnt_reg <= 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store responses are registered on the accept edge; load responses on the edge leaving RESP.
  always_comb begin
    req_ready       = (state_reg == IDLE);
    resp_valid_next = 1'b0;
    read_data_next  = 32'h0;
    error_next      = 1'b0;
    if (accept && write_enable) begin
      resp_valid_next = 1'b1;
      error_next      = fault;
    end else if (state_reg == RESP && !store_reg) begin
      resp_valid_next = 1'b1;
      error_next      = fault_reg;
      read_data_next  = fault_reg ? 32'h0 : load_value;
    end
  end

  assign resp_valid = resp_valid_reg;
  assign ReadData   = read_data_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: stimulus pushes expected responses into
// a scoreboard queue that an independent monitor drains on every resp_valid.
module tb_data_memory_unit;

  localparam int LAT   = 3;
  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        write_enable;
  logic [1:0]  size;
  logic        unsigned_load;
  logic [31:0] address;
  logic [31:0] WriteData;
  logic        resp_valid;
  logic [31:0] ReadData;
  logic        error;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_cnt = 0;
  int   last_accept = 0;
  int   last_waits = 0;

  data_memory_unit #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (32),
    .BASE_ADDRESS (32'h1001_0000),
    .READ_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .write_enable  (write_enable),
    .size          (size),
    .unsigned_load (unsigned_load),
    .address       (address),
    .WriteData     (WriteData),
    .resp_valid    (resp_valid),
    .ReadData      (ReadData),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor: every response must match the oldest scoreboard entry, including its cycle.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: ReadData=%h error=%b cycle=%0d, required no response",
                 ReadData, error, cycle_cnt);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (ReadData !== e.data || error !== e.err || cycle_cnt != e.cyc) begin
          errors++;
          $display("FAIL %s: ReadData=%h error=%b cycle=%0d, required ReadData=%h error=%b cycle=%0d",
                   e.name, ReadData, error, cycle_cnt, e.data, e.err, e.cyc);
        end else begin
          $display("resp %-14s ReadData=%h error=%b cycle=%0d", e.name, ReadData, error, cycle_cnt);
        end
      end
    end else begin
      checks++;
      if (resp_valid !== 1'b0 || ReadData !== 32'h0 || error !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: resp_valid=%b ReadData=%h error=%b cycle=%0d, required 0/0/0",
                 resp_valid, ReadData, error, cycle_cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end else begin
      $display("check %-14s value=%h", nm, act);
    end
  endtask

  // Presents a request (leaving req_valid high afterwards) and returns right after the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e,
                       input bit push, input string nm);
    int   waits;
    exp_t e;
    @(negedge clk);
    req_valid     = 1'b1;
    write_enable  = we;
    size          = sz;
    unsigned_load = uns;
    address       = addr;
    WriteData     = wd;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    last_waits = waits;
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout: req_ready=%b, required 1 within 20 cycles", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    last_accept = cycle_cnt + 1;
    if (push) begin
      e.data = exp_d;
      e.err  = exp_e;
      e.cyc  = we ? last_accept : last_accept + LAT;
      e.name = nm;
      sb_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int a0;
    int waited;
    reset         = 1'b0;
    req_valid     = 1'b0;
    write_enable  = 1'b0;
    size          = 2'b10;
    unsigned_load = 1'b0;
    address       = 32'h0;
    WriteData     = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_read_data", ReadData, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // basic word store/load
    issue(1, 2'b10, 0, 32'h1001_0000, 32'hFFFF_FFFF, 32'h0,         0, 1, "sw_base");
    issue(0, 2'b10, 0, 32'h1001_0000, 32'h0,         32'hFFFF_FFFF, 0, 1, "lw_base");
    // sub-word stores and extended loads
    issue(1, 2'b10, 0, 32'h1001_0004, 32'h1234_5678, 32'h0, 0, 1, "sw_w1");
    a0 = last_accept;
    issue(1, 2'b00, 0, 32'h1001_0005, 32'h7777_77AB, 32'h0, 0, 1, "sb_lane1");
    chk("store_spacing", 32'(last_accept - a0), 32'd2);
    issue(0, 2'b10, 0, 32'h1001_0004, 32'h0, 32'h1234_AB78, 0, 1, "lw_w1");
    issue(0, 2'b00, 0, 32'h1001_0005, 32'h0, 32'hFFFF_FFAB, 0, 1, "lb_lane1");
    issue(0, 2'b00, 1, 32'h1001_0005, 32'h0, 32'h0000_00AB, 0, 1, "lbu_lane1");
    issue(0, 2'b01, 0, 32'h1001_0006, 32'h0, 32'h0000_1234, 0, 1, "lh_upper");
    issue(0, 2'b01, 1, 32'h1001_0004, 32'h0, 32'h0000_AB78, 0, 1, "lhu_lower");
    issue(0, 2'b01, 0, 32'h1001_0004, 32'h0, 32'hFFFF_AB78, 0, 1, "lh_lower");
    issue(0, 2'b00, 0, 32'h1001_0007, 32'h0, 32'h0000_0012, 0, 1, "lb_lane3");
    // faults: misaligned / illegal size stores must not write
    issue(1, 2'b10, 0, 32'h1001_0002, 32'hDEAD_BEEF, 32'h0, 1, 1, "sw_misalign");
    issue(0, 2'b10, 0, 32'h1001_0000, 32'h0, 32'hFFFF_FFFF, 0, 1, "lw_after_bad");
    issue(1, 2'b11, 0, 32'h1001_0000, 32'h0, 32'h0, 1, 1, "st_size11");
    issue(1, 2'b01, 0, 32'h1001_0003, 32'h0, 32'h0, 1, 1, "sh_misalign");
    issue(0, 2'b10, 0, 32'h1001_0000, 32'h0, 32'hFFFF_FFFF, 0, 1, "lw_unchanged");
    issue(0, 2'b11, 0, 32'h1001_0000, 32'h0, 32'h0, 1, 1, "ld_size11");
    issue(0, 2'b01, 0, 32'h1001_0005, 32'h0, 32'h0, 1, 1, "lh_misalign");
    // address range boundaries
    issue(0, 2'b10, 0, 32'h1000_FFFC, 32'h0, 32'h0, 1, 1, "lw_below");
    issue(0, 2'b10, 0, 32'h1001_0000 + 32'(4*DEPTH), 32'h0, 32'h0, 1, 1, "lw_past_end");
    issue(1, 2'b00, 0, 32'h1001_0000 + 32'(4*DEPTH), 32'h0, 32'h0, 1, 1, "sb_past_end");
    issue(1, 2'b10, 0, 32'h1001_0000 + 32'(4*(DEPTH-1)), 32'hCAFE_F00D, 32'h0, 0, 1, "sw_last");
    issue(0, 2'b10, 0, 32'h1001_0000 + 32'(4*(DEPTH-1)), 32'h0, 32'hCAFE_F00D, 0, 1, "lw_last");
    issue(1, 2'b01, 0, 32'h1001_00FE, 32'hAAAA_5555, 32'h0, 0, 1, "sh_last_hi");
    issue(0, 2'b10, 0, 32'h1001_00FC, 32'h0, 32'h5555_F00D, 0, 1, "lw_last2");
    idle(3);

    // back-to-back loads with req_valid held high
    issue(0, 2'b10, 0, 32'h1001_0000, 32'h0, 32'hFFFF_FFFF, 0, 1, "b2b_0");
    a0 = last_accept;
    issue(0, 2'b10, 0, 32'h1001_0004, 32'h0, 32'h1234_AB78, 0, 1, "b2b_1");
    chk("b2b_spacing1", 32'(last_accept - a0), 32'(LAT + 1));
    a0 = last_accept;
    issue(0, 2'b10, 0, 32'h1001_00FC, 32'h0, 32'h5555_F00D, 0, 1, "b2b_2");
    chk("b2b_spacing2", 32'(last_accept - a0), 32'(LAT + 1));
    idle(LAT + 3);

    // reset one cycle after a load accept drops the response
    issue(0, 2'b10, 0, 32'h1001_0000, 32'h0, 32'h0, 0, 0, "ld_dropped");
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_req_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_read_data", ReadData, 32'h0);
    chk("mid_error", {31'h0, error}, 32'h0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    issue(0, 2'b10, 0, 32'h1001_0004, 32'h0, 32'h1234_AB78, 0, 1, "lw_post_rst");
    waited = last_waits;
    chk("post_rst_wait", 32'(waited), 32'd0);
    issue(0, 2'b10, 0, 32'h1001_0000, 32'h0, 32'hFFFF_FFFF, 0, 1, "lw_mem_kept");
    idle(1);

    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
